// File: rtl/rgb_delay_pkg.sv
// Shared definitions for the per-colour edge delay line: default widths and
// the edge shaper state encoding.
package rgb_delay_pkg;

    localparam int DELAY_W_DEF = 4;
    localparam int DROP_W_DEF  = 8;

    // LOW/HIGH are settled output levels; the *_WAIT states count out the
    // extra delay applied to a pending edge before the output follows it.
    typedef enum logic [1:0] {
        LOW       = 2'd0,
        RISE_WAIT = 2'd1,
        HIGH      = 2'd2,
        FALL_WAIT = 2'd3
    } shaper_state_t;

    // The output is driven high while high or while a falling edge is still
    // being held off.
    function automatic logic drives_high(input shaper_state_t s);
        return (s == HIGH) || (s == FALL_WAIT);
    endfunction

endpackage

// File: rtl/rgb_edge_delay_line_shaper.sv
// Edge shaper: stretches rising edges by r_q cycles and falling edges by
// f_q cycles. A pulse or gap that ends before its edge delay expires is
// swallowed and counted once in a saturating drop counter.
module rgb_edge_shaper
    import rgb_delay_pkg::*;
#(
    parameter int DELAY_W = DELAY_W_DEF,
    parameter int DROP_W  = DROP_W_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_dw,
    input  logic [DELAY_W-1:0] i_r_q,
    input  logic [DELAY_W-1:0] i_f_q,
    output logic               o_is_low,
    output logic               o_drive_next,
    output shaper_state_t      o_state,
    output logic [DROP_W-1:0]  o_drop_cnt
);

    localparam logic [DELAY_W-1:0] CNT_ONE  = {{(DELAY_W-1){1'b0}}, 1'b1};
    localparam logic [DROP_W-1:0]  DROP_ONE = {{(DROP_W-1){1'b0}}, 1'b1};

    shaper_state_t      r_state;
    shaper_state_t      w_state_next;
    logic [DELAY_W-1:0] r_cnt;
    logic [DELAY_W-1:0] w_cnt_next;
    logic [DROP_W-1:0]  r_drop_cnt;
    logic               w_drop_inc;

    // State, countdown and saturating drop counter registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= LOW;
            r_cnt      <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_drop_inc && (r_drop_cnt != {DROP_W{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + DROP_ONE;
            end
        end
    end

    // Next-state and countdown logic; a reversal of dw during a wait state
    // wins over an expiring count so a too-short pulse is always swallowed.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_drop_inc   = 1'b0;
        case (r_state)
            LOW: begin
                if (i_dw) begin
                    if (i_r_q == '0) begin
                        w_state_next = HIGH;
                    end else begin
                        w_state_next = RISE_WAIT;
                        w_cnt_next   = i_r_q - CNT_ONE;
                    end
                end
            end
            RISE_WAIT: begin
                if (!i_dw) begin
                    w_state_next = LOW;
                    w_drop_inc   = 1'b1;
                end else if (r_cnt == '0) begin
                    w_state_next = HIGH;
                end else begin
                    w_cnt_next = r_cnt - CNT_ONE;
                end
            end
            HIGH: begin
                if (!i_dw) begin
                    if (i_f_q == '0) begin
                        w_state_next = LOW;
                    end else begin
                        w_state_next = FALL_WAIT;
                        w_cnt_next   = i_f_q - CNT_ONE;
                    end
                end
            end
            FALL_WAIT: begin
                if (i_dw) begin
                    w_state_next = HIGH;
                    w_drop_inc   = 1'b1;
                end else if (r_cnt == '0) begin
                    w_state_next = LOW;
                end else begin
                    w_cnt_next = r_cnt - CNT_ONE;
                end
            end
            default: begin
                w_state_next = LOW;
            end
        endcase
    end

    assign o_is_low     = (r_state == LOW);
    assign o_drive_next = drives_high(w_state_next);
    assign o_state      = r_state;
    assign o_drop_cnt   = r_drop_cnt;

endmodule

// File: rtl/rgb_edge_delay_line.sv
// One colour channel of the LED drive path: whole-cycle delay via a tapped
// shift register, edge shaping, and a polarity-adjusted registered output.
// Delay words are committed only at a frame boundary while the shaper is
// idle in LOW, so a reconfiguration never cuts a pulse in half.
// frame_start is a single-cycle strobe with no handshake; a strobe that
// arrives while the shaper is busy is remembered in cfg_pending and the
// commit happens on the first cycle the shaper is back in LOW, using the
// *_value inputs present in that cycle.
module rgb_edge_delay_line
    import rgb_delay_pkg::*;
#(
    parameter int DELAY_W = DELAY_W_DEF,
    parameter int DROP_W  = DROP_W_DEF
) (
    input  logic               clk_x10,
    input  logic               g_rst,
    input  logic               inverse,
    input  logic               frame_start,
    input  logic               din,
    input  logic [DELAY_W-1:0] whole_delay_value,
    input  logic [DELAY_W-1:0] rising_delay_value,
    input  logic [DELAY_W-1:0] falling_delay_value,
    output logic               dout,
    output logic               cfg_pending,
    output logic [DROP_W-1:0]  drop_cnt,
    output shaper_state_t      dbg_state
);

    localparam int DEPTH = 2 ** DELAY_W;

    logic [DEPTH-1:0]   r_sr;
    logic [DELAY_W-1:0] r_w_q;
    logic [DELAY_W-1:0] r_r_q;
    logic [DELAY_W-1:0] r_f_q;
    logic               r_pending;
    logic               r_dout;
    logic               w_dw;
    logic               w_is_low;
    logic               w_drive_next;
    logic               w_commit;

    // Whole-cycle delay line; the history is kept across commits.
    always_ff @(posedge clk_x10) begin
        if (g_rst) begin
            r_sr <= '0;
        end else begin
            r_sr <= {r_sr[DEPTH-2:0], din};
        end
    end

    assign w_dw     = r_sr[r_w_q];
    assign w_commit = w_is_low && (frame_start || r_pending);

    // Active delay words and the deferred-commit flag.
    always_ff @(posedge clk_x10) begin
        if (g_rst) begin
            r_w_q     <= '0;
            r_r_q     <= '0;
            r_f_q     <= '0;
            r_pending <= 1'b0;
        end else begin
            if (w_commit) begin
                r_w_q <= whole_delay_value;
                r_r_q <= rising_delay_value;
                r_f_q <= falling_delay_value;
            end
            if (w_commit) begin
                r_pending <= 1'b0;
            end else if (frame_start) begin
                r_pending <= 1'b1;
            end
        end
    end

    rgb_edge_shaper #(
        .DELAY_W (DELAY_W),
        .DROP_W  (DROP_W)
    ) u_shaper (
        .i_clk        (clk_x10),
        .i_rst        (g_rst),
        .i_dw         (w_dw),
        .i_r_q        (r_r_q),
        .i_f_q        (r_f_q),
        .o_is_low     (w_is_low),
        .o_drive_next (w_drive_next),
        .o_state      (dbg_state),
        .o_drop_cnt   (drop_cnt)
    );

    // Output register; it loads the idle level during reset so the pin
    // shows the correct polarity on the first cycle after reset.
    always_ff @(posedge clk_x10) begin
        if (g_rst) begin
            r_dout <= inverse;
        end else begin
            r_dout <= w_drive_next ^ inverse;
        end
    end

    // The pin is held low for as long as reset is asserted.
    assign dout        = r_dout & ~g_rst;
    assign cfg_pending = r_pending;

endmodule

// File: tb/tb_rgb_edge_delay_line.sv
// Directed bench for rgb_edge_delay_line: a table of single-pulse cases with
// hand-computed latency/width/drop results, plus hand-written sequences for
// drop saturation, deferred commit and mid-pulse reset.
module tb_rgb_edge_delay_line;
    import rgb_delay_pkg::*;

    logic          clk_x10 = 1'b0;
    logic          g_rst = 1'b1;
    logic          inverse = 1'b0;
    logic          frame_start = 1'b0;
    logic          din = 1'b0;
    logic [3:0]    whole_delay_value = '0;
    logic [3:0]    rising_delay_value = '0;
    logic [3:0]    falling_delay_value = '0;
    logic          dout;
    logic          cfg_pending;
    logic [7:0]    drop_cnt;
    shaper_state_t dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_x10 = ~clk_x10;

    rgb_edge_delay_line dut (
        .clk_x10             (clk_x10),
        .g_rst               (g_rst),
        .inverse             (inverse),
        .frame_start         (frame_start),
        .din                 (din),
        .whole_delay_value   (whole_delay_value),
        .rising_delay_value  (rising_delay_value),
        .falling_delay_value (falling_delay_value),
        .dout                (dout),
        .cfg_pending         (cfg_pending),
        .drop_cnt            (drop_cnt),
        .dbg_state           (dbg_state)
    );

    typedef struct {
        int w;
        int r;
        int f;
        int inv;
        int width;
        int lat;
        int outw;
        int drop;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock cycle: inputs change 1 time unit after the edge, outputs are
    // sampled 3 time units after the edge (well clear of both edges).
    task automatic step(input logic d, input logic fs, input logic rst);
        @(posedge clk_x10);
        #1;
        din         = d;
        frame_start = fs;
        g_rst       = rst;
        #2;
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b1);
        check("rst_dout_during", {31'd0, dout}, 32'd0);
        step(1'b0, 1'b0, 1'b0);
        check("rst_dout_after", {31'd0, dout}, {31'd0, inverse});
        check("rst_pending", {31'd0, cfg_pending}, 32'd0);
        check("rst_drop", {24'd0, drop_cnt}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, {30'd0, LOW});
    endtask

    task automatic commit(input int w, input int r, input int f);
        whole_delay_value   = 4'(w);
        rising_delay_value  = 4'(r);
        falling_delay_value = 4'(f);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic exp_d;
        logic bad_idle;

        //         w   r   f  inv width lat outw drop
        vecs[0] = '{0,  0,  0, 0,  5,   2,  5,   0};
        vecs[1] = '{3,  2,  0, 0,  6,   7,  4,   0};
        vecs[2] = '{0,  0,  0, 1,  4,   2,  4,   0};
        vecs[3] = '{2,  1,  3, 0,  4,   5,  6,   0};
        vecs[4] = '{15, 0,  0, 0,  1,   17, 1,   0};
        vecs[5] = '{0,  0,  15, 0, 1,   2,  16,  0};
        vecs[6] = '{0,  5,  0, 0,  3,   0,  0,   1};
        vecs[7] = '{0,  3,  0, 0,  3,   0,  0,   1};
        vecs[8] = '{0,  3,  0, 0,  4,   5,  1,   0};
        vecs[9] = '{15, 15, 0, 0,  16,  32, 1,   0};

        // Single-pulse table: reset, commit, pulse at k=0, check every cycle.
        for (int v = 0; v < 10; v++) begin
            inverse = vecs[v].inv[0];
            do_reset();
            commit(vecs[v].w, vecs[v].r, vecs[v].f);
            for (int k = 0; k < 64; k++) begin
                step(k < vecs[v].width, 1'b0, 1'b0);
                exp_d = ((k >= vecs[v].lat) && (k < vecs[v].lat + vecs[v].outw)) ^ vecs[v].inv[0];
                check($sformatf("vec%0d_dout_k%0d", v, k), {31'd0, dout}, {31'd0, exp_d});
            end
            check($sformatf("vec%0d_drop", v), {24'd0, drop_cnt}, 32'(vecs[v].drop));
        end

        // Swallowed pulses accumulate and the counter saturates.
        inverse  = 1'b0;
        bad_idle = 1'b0;
        do_reset();
        commit(0, 5, 0);
        for (int p = 0; p < 300; p++) begin
            for (int k = 0; k < 6; k++) begin
                step(k < 3, 1'b0, 1'b0);
                if (dout !== 1'b0) bad_idle = 1'b1;
            end
            if (p == 9) check("sat_drop_10", {24'd0, drop_cnt}, 32'd10);
        end
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 1'b0);
        check("sat_dout_idle", {31'd0, bad_idle}, 32'd0);
        check("sat_drop_255", {24'd0, drop_cnt}, 32'd255);

        // Deferred commit: strobe while high, commit on return to LOW. The
        // shift register history is not cleared, so the new tap of 7 replays
        // the tail of the old pulse.
        do_reset();
        commit(2, 0, 0);
        whole_delay_value = 4'd7;
        for (int k = 0; k < 40; k++) begin
            step(k < 20, (k == 10) || (k == 15), 1'b0);
            if (k == 9)  check("def_pending_before", {31'd0, cfg_pending}, 32'd0);
            if (k == 11) check("def_pending_set", {31'd0, cfg_pending}, 32'd1);
            if (k == 16) check("def_pending_hold", {31'd0, cfg_pending}, 32'd1);
            if (k == 23) check("def_old_w_high", {31'd0, dout}, 32'd1);
            if (k == 23) check("def_pending_23", {31'd0, cfg_pending}, 32'd1);
            if (k == 24) check("def_old_w_fall", {31'd0, dout}, 32'd0);
            if (k == 24) check("def_pending_24", {31'd0, cfg_pending}, 32'd1);
            if (k == 24) check("def_state_low", {30'd0, dbg_state}, {30'd0, LOW});
            if (k == 25) check("def_pending_clr", {31'd0, cfg_pending}, 32'd0);
            if (k >= 25) check($sformatf("def_replay_k%0d", k), {31'd0, dout},
                               {31'd0, (k >= 26) && (k <= 28)});
        end
        for (int k = 0; k < 30; k++) begin
            step(k < 4, 1'b0, 1'b0);
            check($sformatf("def_new_w_k%0d", k), {31'd0, dout}, {31'd0, (k >= 9) && (k <= 12)});
        end

        // Reset mid falling-edge hold, with a commit pending.
        inverse = 1'b0;
        do_reset();
        commit(0, 0, 9);
        for (int k = 0; k < 23; k++) begin
            step((k <= 9) || ((k >= 13) && (k <= 17)), k == 21, k == 22);
            if (k == 20) check("rst_mid_drop_gap", {24'd0, drop_cnt}, 32'd1);
            if (k == 21) check("rst_mid_state_fw", {30'd0, dbg_state}, {30'd0, FALL_WAIT});
            if (k == 21) check("rst_mid_dout_fw", {31'd0, dout}, 32'd1);
            if (k == 22) check("rst_mid_pending", {31'd0, cfg_pending}, 32'd1);
            if (k == 22) check("rst_mid_dout_gated", {31'd0, dout}, 32'd0);
        end
        step(1'b0, 1'b0, 1'b0);
        check("rst_mid_dout_after", {31'd0, dout}, 32'd0);
        check("rst_mid_state_after", {30'd0, dbg_state}, {30'd0, LOW});
        check("rst_mid_pending_after", {31'd0, cfg_pending}, 32'd0);
        check("rst_mid_drop_after", {24'd0, drop_cnt}, 32'd0);
        for (int k = 0; k < 20; k++) begin
            step(k < 3, 1'b0, 1'b0);
            check($sformatf("rst_mid_zero_delay_k%0d", k), {31'd0, dout},
                  {31'd0, (k >= 2) && (k <= 4)});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
